quad_click_sched: RTL
=====================

Name: quad_click_sched

Overview:
- Controller that sequences the 2-bit quadrature steering output from two requesters: a digital joystick (left/right held) and a signed step-delta stream from a mouse or spinner front end.
- Arbitrates between the requesters, converts each granted step into one full quadrature "click" (4 edges, returning to 00), and paces phases with a programmable divider.
- Accelerates the click rate while the joystick is held.
- Drives the core's steering input directly.

Parameters:
- ACC_W, 8: width of the signed pending-step accumulator and of the delta input.
- RAMP_CLICKS, 4: consecutive held-joystick clicks between each period halving.

Ports:
- CLK  input  1  system clock
- RESET  input  1  asynchronous active-high reset
- clkdiv  input  32  base phase period (ticks = clkdiv+1 cycles)
- clkdiv_min  input  32  fastest phase period under acceleration
- left  input  1  joystick left held
- right  input  1  joystick right held
- delta_valid  input  1  delta word offered
- delta  input  ACC_W  signed step count; positive = right
- delta_ready  output  1  delta accepted when valid&ready
- steer  output  2  quadrature phase pair
- busy  output  1  click in progress
- dir  output  1  direction of current/last click, 1 = right

Behaviour:
- Clock and reset: one clock CLK; RESET asynchronous, active-high.
- Reset values: steer=00, busy=0, dir=0, accumulator=0, timer=0, period=clkdiv, hold count=0, state IDLE. delta_ready is combinational and reads 1 while the accumulator is 0.
- Timer and ticks:
  - A tick is a cycle with timer==0. On a tick the timer reloads with the current period; otherwise it decrements.
  - Each phase lasts period+1 cycles. clkdiv=0 gives one tick per cycle.
- States: IDLE, P0, P1, P2, P3. Transitions occur only on ticks.
- IDLE on a tick, source selection:
  - Joystick: exactly one of left/right high selects that direction. left&right both high counts as no joystick request.
  - Accumulator: used only when the joystick has no request and acc≠0. acc>0 gives right and acc decrements; acc<0 gives left and acc increments.
  - On a selected request: latch dir, go to P0.
  - No request: stay in IDLE, steer=00.
- Click sequence: P0 drives 00, then P1, P2, P3 each drive their phase, then IDLE drives 00.
  - Left: P1=01, P2=11, P3=10.
  - Right: P1=10, P2=11, P3=01.
  - steer is registered and updates in the cycle after the tick that causes the transition.
  - One click = 5 ticks.
- A click always completes. Input changes mid-click affect only the next IDLE decision; only RESET aborts a click.
- busy=1 in P0..P3.
- Delta handshake:
  - Accept on delta_valid&delta_ready: acc <= acc + delta, saturating at ±(2^(ACC_W-1)-1).
  - delta_ready=0 only when acc equals +max or -max.
  - An accept in the same cycle as an accumulator-sourced click start applies both: acc + delta ∓ 1, then saturate.
- Acceleration:
  - Hold count increments at each joystick-sourced click start with the same direction as the previous click.
  - The hold count resets to 0 and period reloads clkdiv on any IDLE tick with no joystick request, on a direction change, or on an accumulator-sourced click.
  - When the hold count reaches RAMP_CLICKS: period <= max(period>>1, floor), where floor = min(clkdiv, clkdiv_min); then the hold count clears.
  - Period changes only at click start.
- clkdiv/clkdiv_min changes take effect at the next timer reload.

Optional Feature:
- QUAD_JOY_ACCEL_EN defined: acceleration as described above.
- Not defined: period is always clkdiv, clkdiv_min is ignored, and no hold counter is built.

Test Plan:
- Reset held, then released with all inputs 0, clkdiv=3 -> steer=00, busy=0, delta_ready=1 for 100 cycles.
- clkdiv=3, left pulsed for 1 cycle, aligned to an IDLE tick -> steer 00,01,11,10,00 with each phase 4 cycles; busy high for 16 cycles; dir=0.
- delta=+3 accepted, joystick idle, clkdiv=0 -> three right clicks back-to-back (00,10,11,01 ×3), acc reaches 0, delta_ready stays 1.
- ACC_W=8, delta=+100 twice -> acc saturates at 127; delta_ready=0 until the first click start, then 1.
- QUAD_JOY_ACCEL_EN, clkdiv=15, clkdiv_min=2, right held 40 clicks -> period 15 for clicks 1–4, 7 for 5–8, 3 for 9–12, 2 thereafter; release -> next click uses 15.
- Mid-click RESET during P2 -> steer=00 and busy=0 immediately (async); acc=0.

Source files
------------

// File: rtl/quad_click_sched.sv
// quad_click_sched: arbitrates joystick and delta-accumulator requests into paced quadrature clicks on steer.
// Define QUAD_JOY_ACCEL_EN to build held-joystick acceleration; otherwise the phase period is always clkdiv.
module quad_click_sched #(
  parameter int ACC_W = 8,
  parameter int RAMP_CLICKS = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [31:0]      clkdiv,
  input  logic [31:0]      clkdiv_min,
  input  logic             left,
  input  logic             right,
  input  logic             delta_valid,
  input  logic [ACC_W-1:0] delta,
  output logic             delta_ready,
  output logic [1:0]       steer,
  output logic             busy,
  output logic             dir
);
  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3} state_t;
  localparam logic signed [ACC_W+1:0] MAXV = (ACC_W+2)'((1 << (ACC_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] AMAX = ACC_W'((1 << (ACC_W-1)) - 1);
  state_t state, state_nxt;
  logic [31:0] timer, per_nxt;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic signed [ACC_W+1:0] ext_acc, ext_add, dec, sum;
  logic tick, idle_tick, joy_req, acc_req, acc_take, start, sel_dir, dir_nxt, accept;
  logic [1:0] steer_nxt;
  logic busy_nxt;
  assign tick        = timer == '0;
  assign idle_tick   = tick && state == IDLE;
  assign joy_req     = left ^ right;
  assign acc_req     = !joy_req && acc != '0;
  assign acc_take    = idle_tick && acc_req;
  assign start       = idle_tick && (joy_req || acc_req);
  assign sel_dir     = joy_req ? right : !acc[ACC_W-1];
  assign dir_nxt     = start ? sel_dir : dir;
  assign delta_ready = acc != AMAX && acc != -AMAX;
  assign accept      = delta_valid && delta_ready;
  always_comb begin
    ext_acc = {{2{acc[ACC_W-1]}}, acc};
    ext_add = accept ? {{2{delta[ACC_W-1]}}, delta} : '0;
    dec     = !acc_take ? '0 : acc[ACC_W-1] ? (ACC_W+2)'(1) : '1;
    sum     = ext_acc + ext_add + dec;
    acc_nxt = sum > MAXV ? AMAX : sum < -MAXV ? -AMAX : sum[ACC_W-1:0];
  end
`ifdef QUAD_JOY_ACCEL_EN
  localparam int HW = $clog2(RAMP_CLICKS + 1);
  logic [HW-1:0] hold, hold_nxt;
  logic [5:0] sh, sh_nxt;
  logic ramp_rst, ramp_inc, hit;
  logic [31:0] shifted, floor_v;
  // Period is tracked as a halving count so the reset value needs no live clkdiv.
  always_comb begin
    ramp_rst = idle_tick && (!joy_req || right != dir);
    ramp_inc = idle_tick && joy_req && right == dir;
    hit      = (hold + HW'(1)) == HW'(RAMP_CLICKS);
    sh_nxt   = ramp_rst ? '0 : (ramp_inc && hit && sh != 6'd32) ? sh + 6'd1 : sh;
    hold_nxt = (ramp_rst || (ramp_inc && hit)) ? '0 : ramp_inc ? hold + HW'(1) : hold;
    shifted  = clkdiv >> sh_nxt;
    floor_v  = clkdiv_min < clkdiv ? clkdiv_min : clkdiv;
    per_nxt  = shifted > floor_v ? shifted : floor_v;
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      hold <= '0;
      sh   <= '0;
    end else begin
      hold <= hold_nxt;
      sh   <= sh_nxt;
    end
`else
  logic unused_min;
  assign unused_min = ^clkdiv_min;
  assign per_nxt    = clkdiv;
`endif
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (tick)
      case (state)
        IDLE:    state_nxt = (joy_req || acc_req) ? P0 : IDLE;
        P0:      state_nxt = P1;
        P1:      state_nxt = P2;
        P2:      state_nxt = P3;
        default: state_nxt = IDLE;
      endcase
  end
  always_comb begin
    steer_nxt = state_nxt == P1 ? (dir_nxt ? 2'b10 : 2'b01) :
                state_nxt == P2 ? 2'b11 :
                state_nxt == P3 ? (dir_nxt ? 2'b01 : 2'b10) : 2'b00;
    busy_nxt  = state_nxt != IDLE;
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      timer <= '0;
      acc   <= '0;
      steer <= 2'b00;
      busy  <= 1'b0;
      dir   <= 1'b0;
    end else begin
      timer <= tick ? per_nxt : timer - 32'd1;
      acc   <= acc_nxt;
      steer <= steer_nxt;
      busy  <= busy_nxt;
      dir   <= dir_nxt;
    end
endmodule
